// File: rtl/rx_pack_pkg.sv
// -----------------------------------------------------------------------------
// rx_pack_pkg
// This package holds the definitions shared by rx_word_packer and
// rx_pack_timeout:
//   - the packer FSM state encoding
//   - the EOT character
//   - the default word size and the default flush timeout
// -----------------------------------------------------------------------------
package rx_pack_pkg;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_ACK     = 2'd1,
        ST_OUTPUT  = 2'd2,
        ST_DONE    = 2'd3
    } pack_state_t;

    localparam logic [7:0] EOT_CHAR           = 8'h04;
    localparam int         DEF_WORD_BYTES     = 4;
    localparam int         DEF_TIMEOUT_CYCLES = 100000;

endpackage

// File: rtl/rx_pack_timeout.sv
// -----------------------------------------------------------------------------
// rx_pack_timeout
// Idle counter for flushing a partial word. It is built only when
// RX_PACK_TIMEOUT_EN is defined.
//
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   inc        : an idle cycle with a partial word held. When inc is low,
//                the count restarts from zero.
//   expired    : the current idle cycle is number TIMEOUT_CYCLES. The
//                packer moves to OUTPUT on this edge.
// -----------------------------------------------------------------------------
module rx_pack_timeout
    import rx_pack_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    output logic expired
);

    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] cnt;

    // The expiry decode is one count early, so the flush happens on the same
    // edge that would make the count equal TIMEOUT_CYCLES.
    assign expired = inc && (cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (!inc || expired)
            cnt <= '0;
        else
            cnt <= cnt + TW'(1);
    end

endmodule

// File: rtl/rx_word_packer.sv
// -----------------------------------------------------------------------------
// rx_word_packer
// Packs bytes from a UART RX buffer into WORD_BYTES-wide words for the
// crypter.
//   - The first byte received goes into the MSB.
//   - An EOT byte flushes any partial word and marks it as the last word.
//     If the word is empty, EOT only ends the message.
//   - Each consumed byte is acknowledged with a registered one-cycle
//     rx_clear pulse.
//   - When the packer is not in COLLECT, a pending byte stays in the RX
//     buffer. This applies backpressure to the buffer.
//
// Optional feature: RX_PACK_TIMEOUT_EN. When this macro is defined, a
// partial word is flushed (word_last=0) after TIMEOUT_CYCLES idle cycles.
//
// Ports:
//   clk, rst_n   : clock and asynchronous active-low reset
//   rx_flag      : a byte is pending in the RX buffer
//   rx_eot       : the pending byte is EOT
//   rx_data      : the pending byte
//   rx_clear     : the pending byte has been consumed (one-cycle pulse)
//   word_data    : the packed word; unfilled slots read 0x00
//   word_valid   : word_data, word_last and word_nbytes are valid
//   word_ready   : the consumer accepts the word
//   word_last    : this word was flushed by EOT
//   word_nbytes  : the number of valid bytes in word_data
//   msg_done     : one-cycle pulse at the end of a message
// -----------------------------------------------------------------------------
module rx_word_packer
    import rx_pack_pkg::*;
#(
    parameter int WORD_BYTES     = DEF_WORD_BYTES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            rx_flag,
    input  logic                            rx_eot,
    input  logic [7:0]                      rx_data,
    output logic                            rx_clear,
    output logic [8*WORD_BYTES-1:0]         word_data,
    output logic                            word_valid,
    input  logic                            word_ready,
    output logic                            word_last,
    output logic [$clog2(WORD_BYTES+1)-1:0] word_nbytes,
    output logic                            msg_done
);

    localparam int CW = $clog2(WORD_BYTES + 1);

    if (WORD_BYTES < 2 || WORD_BYTES > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("rx_word_packer: WORD_BYTES must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    pack_state_t   state;
    logic [CW-1:0] count;
    logic          eot_pend;
    logic          full;
    logic          tmo_expired;

    assign full = (count == CW'(WORD_BYTES));

`ifdef RX_PACK_TIMEOUT_EN
    logic tmo_inc;

    // The counter runs only while a partial word sits idle in COLLECT.
    // Any other cycle restarts it, including the cycle in which a byte
    // is stored.
    assign tmo_inc = (state == ST_COLLECT) && (count != '0) && !rx_flag;

    rx_pack_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (tmo_inc),
        .expired (tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_COLLECT;
            count       <= '0;
            eot_pend    <= 1'b0;
            rx_clear    <= 1'b0;
            word_data   <= '0;
            word_valid  <= 1'b0;
            word_last   <= 1'b0;
            word_nbytes <= '0;
            msg_done    <= 1'b0;
        end else begin
            rx_clear <= 1'b0;
            msg_done <= 1'b0;
            case (state)
                ST_COLLECT: begin
                    if (rx_flag) begin
                        if (rx_eot) begin
                            // The EOT byte itself is never stored.
                            eot_pend <= 1'b1;
                        end else if (!full) begin
                            for (int i = 0; i < WORD_BYTES; i++) begin
                                if (count == CW'(i))
                                    word_data[8*(WORD_BYTES-1-i) +: 8] <= rx_data;
                            end
                            count <= count + CW'(1);
                        end
                        // rx_clear is high for the whole ACK cycle.
                        rx_clear <= 1'b1;
                        state    <= ST_ACK;
                    end else if (tmo_expired) begin
                        word_valid  <= 1'b1;
                        word_last   <= 1'b0;
                        word_nbytes <= count;
                        state       <= ST_OUTPUT;
                    end
                end

                ST_ACK: begin
                    if (full || (eot_pend && count != '0)) begin
                        word_valid  <= 1'b1;
                        word_last   <= eot_pend;
                        word_nbytes <= count;
                        state       <= ST_OUTPUT;
                    end else if (eot_pend) begin
                        state <= ST_DONE;
                    end else begin
                        state <= ST_COLLECT;
                    end
                end

                ST_OUTPUT: begin
                    if (word_ready) begin
                        word_valid  <= 1'b0;
                        word_last   <= 1'b0;
                        word_nbytes <= '0;
                        word_data   <= '0;
                        count       <= '0;
                        state       <= word_last ? ST_DONE : ST_COLLECT;
                    end
                end

                ST_DONE: begin
                    // msg_done is registered, so its pulse follows the
                    // DONE cycle.
                    msg_done <= 1'b1;
                    eot_pend <= 1'b0;
                    state    <= ST_COLLECT;
                end

                default: state <= ST_COLLECT;
            endcase
        end
    end

endmodule
